// File: rtl/reg_dump_ctrl.sv
// rtl/reg_dump_ctrl.sv - sequential register-file dump over a valid/ready stream
// Walks FIRST_REG..LAST_REG through read port A and streams {index, value} beats.
module reg_dump_ctrl #(
  parameter int FIRST_REG = 1,
  parameter int LAST_REG  = 31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  output logic [4:0]  rf_ra,
  input  logic [31:0] rf_data,
  output logic        dump_valid,
  input  logic        dump_ready,
  output logic [4:0]  dump_addr,
  output logic [31:0] dump_data,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_t;

  localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
  localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

  state_t     state;
  logic [4:0] idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= 5'd0;
      rf_ra      <= 5'd0;
      dump_valid <= 1'b0;
      dump_addr  <= 5'd0;
      dump_data  <= 32'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // start wins over a simultaneous abort here
          if (start) begin
            idx   <= FIRST_IDX;
            rf_ra <= FIRST_IDX;
            busy  <= 1'b1;
            state <= READ;
          end
        end
        READ: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            dump_data  <= rf_data;
            dump_addr  <= idx;
            dump_valid <= 1'b1;
            state      <= SEND;
          end
        end
        SEND: begin
          if (abort) begin
            dump_valid <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
          end else if (dump_valid && dump_ready) begin
            dump_valid <= 1'b0;
            if (idx == LAST_IDX) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              idx   <= idx + 5'd1;
              rf_ra <= idx + 5'd1;
              state <= READ;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
